// File: rtl/serial_tx_if.sv
// serial_tx_if: word handshake between a producer and the serial transmitter.
// The producer drives a word and its bit order with valid. The transmitter
// answers with ready. A word is taken on a rising edge where valid and ready
// are both high.
interface serial_tx_if #(
  parameter int N = 8
);
  logic [N-1:0] din;    // parallel word to transmit
  logic         dir;    // 0 = LSB-first, 1 = MSB-first
  logic         valid;  // producer has a word on din/dir
  logic         ready;  // transmitter can accept a word this cycle

  // Producer side (control FSM, FIFO, testbench).
  modport master (
    output din,
    output dir,
    output valid,
    input  ready
  );

  // Transmitter side.
  modport slave (
    input  din,
    input  dir,
    input  valid,
    output ready
  );
endinterface

// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out transmitter.
// A word accepted over the valid/ready handshake is shifted out on sout,
// one bit every DIV clocks, either LSB-first or MSB-first. frame is high
// while the word's bits are on the line. done pulses for one cycle after
// the last bit period. Every word is followed by at least one idle cycle.
// All outputs are registered. ready is high exactly in IDLE.
module serial_tx #(
  parameter int N   = 8,  // word width in bits, N >= 2
  parameter int DIV = 4   // clocks per serial bit, DIV >= 1
) (
  input  logic       clk,
  input  logic       reset,  // synchronous, active-high
  serial_tx_if.slave bus,
  output logic       sout,
  output logic       frame,
  output logic       done
);

  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BCW = $clog2(N);

  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         state;
  logic [N-1:0]   shreg;      // copy of the word, consumed one bit per shift
  logic [N-1:0]   shreg_nxt;  // register contents after the next shift
  logic           order;      // bit order latched with the word
  logic [BCW-1:0] bitcnt;     // index of the bit now on sout
  logic [DCW-1:0] divcnt;     // clocks spent on the current bit
  logic           ready_q;

  assign bus.ready = ready_q;

  // Next shift register value: right shift for LSB-first, left for MSB-first,
  // zero fill. The bit that lands at the output end is the next one to send.
  always_comb begin
    shreg_nxt = order ? (shreg << 1) : (shreg >> 1);
  end

  // Control FSM, datapath and registered outputs.
  // NOTE: every register here uses a non-blocking assignment. All right-hand
  // sides then see values from before the edge, so statement order does not
  // matter and simulation agrees with the synthesized flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      order   <= 1'b0;
      bitcnt  <= '0;
      divcnt  <= '0;
      sout    <= 1'b0;
      frame   <= 1'b0;
      done    <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      // done is a single-cycle strobe; only the final bit period raises it.
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.valid && ready_q) begin
            shreg   <= bus.din;
            order   <= bus.dir;
            bitcnt  <= '0;
            divcnt  <= '0;
            // The first bit goes on the line at the accepting edge.
            sout    <= bus.dir ? bus.din[N-1] : bus.din[0];
            frame   <= 1'b1;
            ready_q <= 1'b0;
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          if (divcnt != DIV_LAST) begin
            // Hold the current bit for another clock.
            divcnt <= divcnt + 1'b1;
          end else if (bitcnt != BIT_LAST) begin
            // Bit period over, more bits left: advance to the next bit.
            shreg  <= shreg_nxt;
            sout   <= order ? shreg_nxt[N-1] : shreg_nxt[0];
            bitcnt <= bitcnt + 1'b1;
            divcnt <= '0;
          end else begin
            // Last bit period over: close the frame and strobe done.
            // ready returns in the same cycle, so a waiting word is taken at
            // the next edge and the line idles for exactly one cycle.
            state   <= IDLE;
            frame   <= 1'b0;
            sout    <= 1'b0;
            done    <= 1'b1;
            ready_q <= 1'b1;
            bitcnt  <= '0;
            divcnt  <= '0;
          end
        end

        default: begin
          state   <= IDLE;
          frame   <= 1'b0;
          sout    <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed self-checking bench for serial_tx.
// dut_a uses DIV=4 and covers reset, both bit orders, input changes during a
// frame, back-to-back words and a reset that aborts a frame.
// dut_b uses DIV=1 and covers one-bit-per-clock framing.
// Expected sout sequences are written by hand as 8-bit patterns:
// bit i of a pattern is the i-th bit to appear on sout.
module tb_serial_tx;

  logic clk = 1'b0;
  logic reset;
  logic sout_a, frame_a, done_a;
  logic sout_b, frame_b, done_b;

  int checks   = 0;
  int failures = 0;

  serial_tx_if #(.N(8)) bus_a ();
  serial_tx_if #(.N(8)) bus_b ();

  serial_tx #(.N(8), .DIV(4)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a),
    .sout  (sout_a),
    .frame (frame_a),
    .done  (done_a)
  );

  serial_tx #(.N(8), .DIV(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b),
    .sout  (sout_b),
    .frame (frame_b),
    .done  (done_b)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Check all four observable outputs of dut_a.
  task automatic outs_a(input string tag, input logic s, input logic f,
                        input logic r, input logic d);
    check({tag, ".sout"},  32'(sout_a),      32'(s));
    check({tag, ".frame"}, 32'(frame_a),     32'(f));
    check({tag, ".ready"}, 32'(bus_a.ready), 32'(r));
    check({tag, ".done"},  32'(done_a),      32'(d));
  endtask

  task automatic outs_b(input string tag, input logic s, input logic f,
                        input logic r, input logic d);
    check({tag, ".sout"},  32'(sout_b),      32'(s));
    check({tag, ".frame"}, 32'(frame_b),     32'(f));
    check({tag, ".ready"}, 32'(bus_b.ready), 32'(r));
    check({tag, ".done"},  32'(done_b),      32'(d));
  endtask

  // Offer word w to dut_a (which must be ready), then follow the whole frame.
  // seq is the expected transmit order. After acceptance, valid/din become
  // nxt_valid/nxt. With disturb set, din and dir are scrambled mid-frame.
  // Returns in the done cycle, after checking it.
  task automatic send_a(input logic [7:0] w, input logic d, input logic [7:0] seq,
                        input logic [7:0] nxt, input logic nxt_valid,
                        input logic disturb, input string tag);
    bus_a.din   = w;
    bus_a.dir   = d;
    bus_a.valid = 1'b1;
    tick();
    bus_a.valid = nxt_valid;
    bus_a.din   = disturb ? 8'h00 : nxt;
    if (disturb) bus_a.dir = ~d;
    for (int i = 0; i < 32; i++) begin
      outs_a($sformatf("%s.c%0d", tag, i), seq[i/4], 1'b1, 1'b0, 1'b0);
      if (disturb && i == 13) begin
        bus_a.dir = d;
        bus_a.din = 8'hFF;
      end
      tick();
    end
    outs_a({tag, ".done_cycle"}, 1'b0, 1'b0, 1'b1, 1'b1);
    if (disturb) begin
      bus_a.dir = d;
      bus_a.din = nxt;
    end
  endtask

  initial begin
    // Reset held for two cycles while both producers offer a word.
    reset       = 1'b1;
    bus_a.din   = 8'hC1;
    bus_a.dir   = 1'b0;
    bus_a.valid = 1'b1;
    bus_b.din   = 8'hA5;
    bus_b.dir   = 1'b0;
    bus_b.valid = 1'b1;
    tick();
    outs_a("rst1_a", 1'b0, 1'b0, 1'b1, 1'b0);
    outs_b("rst1_b", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    outs_a("rst2_a", 1'b0, 1'b0, 1'b1, 1'b0);
    outs_b("rst2_b", 1'b0, 1'b0, 1'b1, 1'b0);
    reset       = 1'b0;
    bus_a.valid = 1'b0;
    bus_b.valid = 1'b0;
    tick();
    outs_a("post_rst_a", 1'b0, 1'b0, 1'b1, 1'b0);
    outs_b("post_rst_b", 1'b0, 1'b0, 1'b1, 1'b0);

    // LSB-first C1: 1,0,0,0,0,0,1,1 -> pattern C1.
    send_a(8'hC1, 1'b0, 8'hC1, 8'h00, 1'b0, 1'b0, "lsb");
    tick();
    outs_a("lsb_idle", 1'b0, 1'b0, 1'b1, 1'b0);

    // MSB-first C1: 1,1,0,0,0,0,0,1 -> pattern 83; din/dir scrambled mid-frame.
    send_a(8'hC1, 1'b1, 8'h83, 8'h00, 1'b0, 1'b1, "msb");
    tick();
    outs_a("msb_idle", 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back: C1 then 3E (0,1,1,1,1,1,0,0 -> pattern 3E), valid held.
    send_a(8'hC1, 1'b0, 8'hC1, 8'h3E, 1'b1, 1'b0, "b2b1");
    send_a(8'h3E, 1'b0, 8'h3E, 8'h00, 1'b0, 1'b0, "b2b2");
    tick();
    outs_a("b2b_idle", 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset during bit 3 of A5 (bits 1,0,1,0,...): cycle 13 carries bit 3 = 0.
    bus_a.din   = 8'hA5;
    bus_a.dir   = 1'b0;
    bus_a.valid = 1'b1;
    tick();
    bus_a.valid = 1'b0;
    outs_a("abort_c0", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) tick();
    outs_a("abort_c13", 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    outs_a("abort_rst", 1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    // The aborted word must never produce frame or done again.
    for (int i = 0; i < 24; i++) begin
      tick();
      outs_a($sformatf("abort_quiet%0d", i), 1'b0, 1'b0, 1'b1, 1'b0);
    end
    // A fresh word afterwards starts from bit 0: 5A LSB-first -> 0,1,0,1,1,0,1,0.
    send_a(8'h5A, 1'b0, 8'h5A, 8'h00, 1'b0, 1'b0, "after_abort");
    tick();
    outs_a("after_abort_idle", 1'b0, 1'b0, 1'b1, 1'b0);

    // DIV=1: A5 LSB-first -> 1,0,1,0,0,1,0,1 on consecutive clocks.
    begin
      logic [7:0] seq_b;
      seq_b       = 8'hA5;
      bus_b.din   = 8'hA5;
      bus_b.dir   = 1'b0;
      bus_b.valid = 1'b1;
      tick();
      bus_b.valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
        outs_b($sformatf("div1.c%0d", i), seq_b[i], 1'b1, 1'b0, 1'b0);
        tick();
      end
      outs_b("div1.done_cycle", 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      outs_b("div1.idle", 1'b0, 1'b0, 1'b1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
